// File: rtl/tt_sweep_gen_if.sv
// Bus between the truth-table sweep generator and the bench/checker around it.
// TT_CHECK_EN adds the expected-table input and the compare result signals.
interface tt_sweep_gen_if #(
  parameter int N_IN = 5
);
  localparam int NV = 2**N_IN;

  logic            start;
  logic            abort;
  logic            f_in;
  logic [N_IN-1:0] vec;
  logic            valid;
  logic            busy;
  logic            done;
  logic [NV-1:0]   tt;
`ifdef TT_CHECK_EN
  logic [NV-1:0]   tt_exp;
  logic [N_IN:0]   err_cnt;
  logic            pass;
`endif

  modport master (
    input  start, abort, f_in,
`ifdef TT_CHECK_EN
    input  tt_exp,
    output err_cnt, pass,
`endif
    output vec, valid, busy, done, tt
  );

  modport slave (
    output start, abort, f_in,
`ifdef TT_CHECK_EN
    output tt_exp,
    input  err_cnt, pass,
`endif
    input  vec, valid, busy, done, tt
  );
endinterface

// File: rtl/tt_sweep_gen.sv
// Walks all 2**N_IN input vectors, holds each HOLD_CYCLES cycles and builds a truth table.
// Optional feature macro: TT_CHECK_EN (compare against tt_exp, err_cnt/pass outputs).
//
// state   | meaning
// S_IDLE  | waiting for start, vec parked at 0
// S_DRIVE | sweeping: vec driven, f_in sampled at end of each hold
// S_DONE  | sweep complete, tt (and err_cnt/pass) valid until next start
module tt_sweep_gen #(
  parameter int N_IN        = 5,
  parameter int HOLD_CYCLES = 10
) (
  input  logic           clk,
  input  logic           rst,
  tt_sweep_gen_if.master bus
);
  localparam int NV = 2**N_IN;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_idx;
  logic [HW-1:0]   r_hold;
  logic [NV-1:0]   r_tt;
  logic            w_sample;
  logic            w_last;
  logic            w_enter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // abort has priority over both start and the end-of-hold sample
  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_last   = 1'b0;
    w_enter  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start && !bus.abort) begin
          w_next  = S_DRIVE;
          w_enter = 1'b1;
        end
      end
      S_DRIVE: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (r_hold == HOLD_LAST) begin
          w_sample = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_tt   <= '0;
    end else if (w_enter) begin
      r_idx  <= '0;
      r_hold <= '0;
      r_tt   <= '0;
    end else if (r_state == S_DRIVE) begin
      if (bus.abort) begin
        r_idx  <= '0;
        r_hold <= '0;
      end else if (w_sample) begin
        r_tt[r_idx] <= bus.f_in;
        r_hold      <= '0;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign bus.vec   = r_idx;
  assign bus.valid = (r_state == S_DRIVE);
  assign bus.busy  = (r_state == S_DRIVE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.tt    = r_tt;

`ifdef TT_CHECK_EN
  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  logic [N_IN:0] r_err;
  logic [N_IN:0] w_err_next;
  logic          r_pass;

  always_comb begin
    w_err_next = r_err;
    if (w_sample && (bus.f_in != bus.tt_exp[r_idx]) && (r_err != ERR_MAX))
      w_err_next = r_err + 1'b1;
  end

  // pass is latched on the final sample so it rises together with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_enter) begin
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_sample) begin
      r_err <= w_err_next;
      if (w_last) r_pass <= (w_err_next == '0);
    end
  end

  assign bus.err_cnt = r_err;
  assign bus.pass    = r_pass;
`endif
endmodule
